// File: rtl/mem_stage_ctrl.sv
// Memory stage: fixed-latency load/store against a local word array, freezing
// upstream stages for the duration of each access, with registered MEM/WB fields.
module mem_stage_ctrl #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] ST_val_in,
  input  logic [3:0]  Dest_in,
  output logic        freeze,
  output logic        WB_en,
  output logic        MEM_R_EN,
  output logic [31:0] ALU_result,
  output logic [31:0] Mem_read_value,
  output logic [3:0]  Dest
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      mem [DEPTH];

  logic             req;
  logic             commit;
  logic [IDX_W-1:0] idx;

  assign req    = MEM_R_EN_in | MEM_W_EN_in;
  // Byte offset from the base, word-aligned; out-of-range addresses wrap.
  assign idx    = IDX_W'((ALU_result_in - 32'(BASE_ADDR)) >> 2);
  assign commit = (state == ACCESS) && (cnt == CNT_W'(WAIT_CYCLES - 1));
  assign freeze = req && (state != DONE);

  // Access sequencing and the MEM/WB output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      WB_en          <= 1'b0;
      MEM_R_EN       <= 1'b0;
      ALU_result     <= '0;
      Mem_read_value <= '0;
      Dest           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt   <= '0;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (commit) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (freeze) begin
        WB_en    <= 1'b0;
        MEM_R_EN <= 1'b0;
      end else begin
        WB_en          <= WB_en_in;
        MEM_R_EN       <= MEM_R_EN_in;
        ALU_result     <= ALU_result_in;
        Dest           <= Dest_in;
        Mem_read_value <= mem[idx];
      end
    end
  end

  // Data array is deliberately not reset; the store lands on the last access edge.
  always_ff @(posedge clk) begin
    if (commit && MEM_W_EN_in) mem[idx] <= ST_val_in;
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: age-based reference model compared every
// cycle, plus directed transactions with hand-computed expectations.
module tb_mem_stage_ctrl;

  localparam int unsigned W    = 5;
  localparam int unsigned D    = 64;
  localparam int unsigned BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WB_en_in = 1'b0;
  logic        MEM_R_EN_in = 1'b0;
  logic        MEM_W_EN_in = 1'b0;
  logic [31:0] ALU_result_in = '0;
  logic [31:0] ST_val_in = '0;
  logic [3:0]  Dest_in = '0;
  logic        freeze;
  logic        WB_en;
  logic        MEM_R_EN;
  logic [31:0] ALU_result;
  logic [31:0] Mem_read_value;
  logic [3:0]  Dest;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  mem_stage_ctrl #(.WAIT_CYCLES(W), .DEPTH(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in), .Dest_in(Dest_in),
    .freeze(freeze), .WB_en(WB_en), .MEM_R_EN(MEM_R_EN),
    .ALU_result(ALU_result), .Mem_read_value(Mem_read_value), .Dest(Dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an access is a window of W+2 cycles counted from the
  // cycle the request is first presented (age 0); the store lands at age W.
  logic [31:0] mem_m [D];
  bit          known [D];
  bit          m_busy = 1'b0;
  int unsigned m_age = 0;
  logic        exp_wb = 1'b0;
  logic        exp_mr = 1'b0;
  logic [31:0] exp_alu = '0;
  logic [31:0] exp_rd = '0;
  logic [3:0]  exp_dest = '0;
  bit          exp_rd_known = 1'b1;

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'(BASE)) >> 2;
    return int'(w % 32'(D));
  endfunction

  function automatic logic model_freeze();
    int unsigned age;
    age = m_busy ? m_age : 0;
    return (MEM_R_EN_in || MEM_W_EN_in) && (age <= W);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int unsigned age;
    int unsigned ix;
    logic        rq;
    logic        fz;
    if (rst) begin
      m_busy = 1'b0; m_age = 0;
      exp_wb = 1'b0; exp_mr = 1'b0; exp_alu = '0; exp_rd = '0; exp_dest = '0;
      exp_rd_known = 1'b1;
    end else begin
      rq  = MEM_R_EN_in || MEM_W_EN_in;
      age = m_busy ? m_age : 0;
      ix  = widx(ALU_result_in);
      if (rq && age == W && MEM_W_EN_in) begin
        mem_m[ix] = ST_val_in;
        known[ix] = 1'b1;
      end
      fz = rq && (age <= W);
      if (fz) begin
        exp_wb = 1'b0;
        exp_mr = 1'b0;
      end else begin
        exp_wb       = WB_en_in;
        exp_mr       = MEM_R_EN_in;
        exp_alu      = ALU_result_in;
        exp_dest     = Dest_in;
        exp_rd       = mem_m[ix];
        exp_rd_known = known[ix];
      end
      if (rq && age < W + 1) begin
        m_busy = 1'b1;
        m_age  = age + 1;
      end else begin
        m_busy = 1'b0;
        m_age  = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("freeze", 32'(freeze), 32'(model_freeze()));
      chk("WB_en", 32'(WB_en), 32'(exp_wb));
      chk("MEM_R_EN", 32'(MEM_R_EN), 32'(exp_mr));
      chk("ALU_result", ALU_result, exp_alu);
      chk("Dest", 32'(Dest), 32'(exp_dest));
      if (exp_rd_known) chk("Mem_read_value", Mem_read_value, exp_rd);
    end
  end

  // Present one instruction and hold it while frozen; returns the stall length.
  task automatic present(input logic wb, input logic r, input logic w,
                         input logic [31:0] alu, input logic [31:0] st,
                         input logic [3:0] dst, output int fcnt);
    WB_en_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
    ALU_result_in = alu; ST_val_in = st; Dest_in = dst;
    fcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!freeze) break;
      fcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    WB_en_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
    ALU_result_in = '0; ST_val_in = '0; Dest_in = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f;
    int f2;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b1;
    chk("rst_WB_en", 32'(WB_en), 32'd0);
    chk("rst_ALU_result", ALU_result, 32'd0);
    chk("rst_Mem_read_value", Mem_read_value, 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    rst = 1'b0;

    @(posedge clk);
    #1;
    present(1'b1, 1'b0, 1'b0, 32'h0000_0007, 32'h0, 4'd3, f);
    chk("add_stall", 32'(f), 32'd0);
    chk("add_WB_en", 32'(WB_en), 32'd1);
    chk("add_ALU_result", ALU_result, 32'd7);
    chk("add_Dest", 32'(Dest), 32'd3);

    present(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd0, f);
    chk("st_stall", 32'(f), 32'd6);
    chk("st_WB_en", 32'(WB_en), 32'd0);
    present(1'b1, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 4'd1, f);
    chk("pass_after_st", ALU_result, 32'h42);

    present(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5, f);
    chk("ld_stall", 32'(f), 32'd6);
    chk("ld_value", Mem_read_value, 32'hDEAD_BEEF);
    chk("ld_MEM_R_EN", 32'(MEM_R_EN), 32'd1);
    chk("ld_Dest", 32'(Dest), 32'd5);

    // 1280 = base + 4*DEPTH aliases word 0
    present(1'b0, 1'b0, 1'b1, 32'd1280, 32'hCAFE_F00D, 4'd0, f);
    present(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd7, f);
    chk("wrap_value", Mem_read_value, 32'hCAFE_F00D);

    // Simultaneous read+write returns the freshly stored word
    present(1'b1, 1'b1, 1'b1, 32'd1040, 32'h0000_0077, 4'd4, f);
    chk("rw_value", Mem_read_value, 32'h0000_0077);
    chk("rw_stall", 32'(f), 32'd6);

    // Reset during the third access cycle of a store must drop the store
    present(1'b0, 1'b0, 1'b1, 32'd1036, 32'h55AA_55AA, 4'd0, f);
    WB_en_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b1;
    ALU_result_in = 32'd1036; ST_val_in = 32'h0000_1234; Dest_in = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    WB_en_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
    ALU_result_in = '0; ST_val_in = '0; Dest_in = '0;
    #1;
    chk("rstmid_WB_en", 32'(WB_en), 32'd0);
    chk("rstmid_MEM_R_EN", 32'(MEM_R_EN), 32'd0);
    chk("rstmid_ALU_result", ALU_result, 32'd0);
    chk("rstmid_Dest", 32'(Dest), 32'd0);
    chk("rstmid_Mem_read_value", Mem_read_value, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rstmid_freeze", 32'(freeze), 32'd0);
    @(posedge clk);
    #1;
    present(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd6, f);
    chk("rstmid_word3", Mem_read_value, 32'h55AA_55AA);

    // Back-to-back load then store, then read the store back
    present(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd9, f);
    chk("b2b_ld_value", Mem_read_value, 32'hDEAD_BEEF);
    present(1'b0, 1'b0, 1'b1, 32'd1032, 32'h0BAD_CAFE, 4'd0, f2);
    chk("b2b_ld_stall", 32'(f), 32'd6);
    chk("b2b_st_stall", 32'(f2), 32'd6);
    present(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd10, f);
    chk("b2b_readback", Mem_read_value, 32'h0BAD_CAFE);

    idle_cycle();
    idle_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory stage of the five-stage pipeline. It consumes the EXE/MEM pipeline fields, performs data-memory loads and stores against an internal word array through a fixed-latency access state machine, and produces the registered MEM/WB fields. While an access is in progress it raises `freeze` so that all upstream stages hold their state.

## Interface
Parameters:
- `WAIT_CYCLES`, 5: access cycles per load/store; legal range ≥1.
- `DEPTH`, 64: data memory words; power of two.
- `BASE_ADDR`, 1024: byte address mapped to word 0.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `WB_en_in` input 1: writeback enable from EXE/MEM.
- `MEM_R_EN_in` input 1: load request.
- `MEM_W_EN_in` input 1: store request.
- `ALU_result_in` input 32: byte address for loads/stores; otherwise the ALU result to forward.
- `ST_val_in` input 32: store data.
- `Dest_in` input 4: destination register.
- `freeze` output 1: combinational stall to upstream stages and to the EXE/MEM register.
- `WB_en` output 1: registered writeback enable.
- `MEM_R_EN` output 1: registered load flag; writeback selects memory data when it is high.
- `ALU_result` output 32: registered ALU result.
- `Mem_read_value` output 32: registered load data.
- `Dest` output 4: registered destination.

## Operation
- `req` = `MEM_R_EN_in | MEM_W_EN_in`.
- Word index = `((ALU_result_in - BASE_ADDR) >> 2)`, low log2(DEPTH) bits. Addresses outside the range wrap modulo DEPTH. Byte offset bits [1:0] are ignored.
- FSM states: IDLE, ACCESS, DONE. A counter `cnt` of width ceil(log2(WAIT_CYCLES+1)) tracks the access.
  - IDLE: if `req`, clear `cnt` and go to ACCESS; otherwise stay in IDLE.
  - ACCESS: increment `cnt`. When `cnt == WAIT_CYCLES-1`, perform the store (if `MEM_W_EN_in`) at that edge and go to DONE.
  - DONE: return to IDLE unconditionally.
- `freeze` = `req & (state != DONE)`. When there is no request, `freeze` = 0.
- Upstream holds its inputs stable while `freeze` = 1. This block does not latch its inputs.
- Output register, updated on each edge:
  - If `freeze`: load a bubble (`WB_en` = 0, `MEM_R_EN` = 0). `ALU_result`, `Dest` and `Mem_read_value` hold.
  - Otherwise: load all `*_in` fields, and set `Mem_read_value` = mem[index] (the combinational array read).
- When `MEM_R_EN_in` and `MEM_W_EN_in` are both set, the store happens first, and the load returns the newly stored value.
- Non-memory instructions pass through in one cycle with no stall.
- Memory contents are not affected by reset and are uninitialised (X) at power-up.

## Timing
- Reset: state = IDLE, `cnt` = 0. `freeze` = 0 (no request present). `WB_en`, `MEM_R_EN`, `ALU_result`, `Mem_read_value` and `Dest` are all 0.
- Non-memory instruction: outputs valid 1 cycle after presentation.
- Memory instruction presented in cycle t:
  - `freeze` is high in cycles t .. t+WAIT_CYCLES.
  - `freeze` is low in cycle t+WAIT_CYCLES+1 (DONE).
  - The store commits at the end of cycle t+WAIT_CYCLES.
  - Registered outputs are valid from cycle t+WAIT_CYCLES+2.
- Back-to-back memory instructions: the second is first seen in IDLE the cycle after DONE. There is no overlap between accesses.
- Reset asserted mid-ACCESS: the FSM returns to IDLE immediately. A store that has not reached its commit edge is lost. Outputs clear.
- If `req` drops mid-ACCESS (protocol violation), behaviour is undefined. Verification flags it as an assertion failure.

## Test plan
- Reset, then present ADD-like fields (`WB_en_in` = 1, `ALU_result_in` = 0x0000_0007, `Dest_in` = 3) -> next cycle `WB_en` = 1, `ALU_result` = 7, `Dest` = 3, `freeze` never asserted.
- Store 0xDEAD_BEEF at 1032, with WAIT_CYCLES = 5 -> `freeze` high for exactly 6 cycles, word 2 = 0xDEADBEEF, then a bubble (`WB_en` = 0) followed by pass-through.
- Load from 1032 after that store (`Dest_in` = 5) -> `freeze` high for 6 cycles, then `Mem_read_value` = 0xDEADBEEF, `MEM_R_EN` = 1, `Dest` = 5.
- Store at 1024 + 4·DEPTH (= 1280) then load from 1024 -> same value returned (wrap-around).
- Assert `rst` in the 3rd ACCESS cycle of a store of 0x1234 to 1036 -> all outputs 0 immediately, `freeze` = 0 after reset releases with inputs idle, word 3 unchanged.
- Load immediately followed by store (upstream held by `freeze`) -> two separate 6-cycle stall windows separated by one non-frozen DONE cycle, and correct data on each access.
